mem_write_buffer: RTL and testbench
===================================

MEM_WRITE_BUFFER -- requirements
Module: mem_write_buffer

Interface
REQ-001 Parameter WB_DEPTH, default 4, number of buffered write entries; power of 2, at least 2.
REQ-002 clk  input  1  clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cache_avn_req  input  avalon_req_t  upstream request from set-associative cache memory port (read, write, address[31:0], writedata[31:0], byte_enable[3:0]).
REQ-005 cache_avn_resp  output  avalon_resp_t  upstream response (readdata[31:0], waitrequest).
REQ-006 mem_avn_req  output  avalon_req_t  downstream request to memory bus.
REQ-007 mem_avn_resp  input  avalon_resp_t  downstream response; readdata valid exactly 1 cycle after an accepted read.
REQ-008 wb_empty  output  1  high when no buffered write is pending; used by fence logic.

Function
REQ-009 Upstream write accepted (waitrequest=0) in same cycle when count < WB_DEPTH and state is NORMAL; address, writedata, byte_enable pushed at tail.
REQ-010 Write with count == WB_DEPTH: waitrequest=1; no push, even if head retires same cycle.
REQ-011 Upstream read hazard = read address[31:2] matches any valid entry address[31:2], or read address[31] = 1 (non-cacheable) with count != 0.
REQ-012 Read without hazard bypasses buffer: mem_avn_req.read=1, address/byte_enable passed through, upstream waitrequest = mem waitrequest; no write issued that cycle.
REQ-013 Read with hazard: state -> DRAIN, upstream waitrequest=1, buffer drains in FIFO order; when count reaches 0 return to NORMAL and issue read per REQ-012.
REQ-014 No upstream read, or state DRAIN: head entry issued as mem_avn_req.write whenever count != 0; pop on mem waitrequest=0.
REQ-015 FIFO order of writes to memory strictly preserved; a read never overtakes a write to the same word.
REQ-016 cache_avn_resp.readdata = mem_avn_resp.readdata combinationally; holds the value returned 1 cycle after the accepted read.
REQ-017 Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
REQ-018 Pointers log2(WB_DEPTH) bits, wrap modulo WB_DEPTH; count log2(WB_DEPTH)+1 bits, range 0..WB_DEPTH.
REQ-019 Simultaneous upstream read and write asserted: protocol error, read takes priority, write ignored.
REQ-020 mem_avn_req fields held stable while mem waitrequest=1.
REQ-021 wb_empty = (count == 0), registered-state derived, no combinational path from inputs.
REQ-022 States: NORMAL (accept writes, bypass reads), DRAIN (reject all upstream, empty buffer); DRAIN -> NORMAL only when count == 0.

Reset
REQ-023 On rst: count=0, head/tail=0, state=NORMAL, wb_empty=1, mem read/write=0, upstream waitrequest=0 next cycle.
REQ-024 Reset mid-operation discards all buffered writes and any in-flight read; no write issued in the reset cycle.
REQ-025 Entry storage not reset; validity defined solely by count/pointers.

Structure
REQ-026 avalon_req_t, avalon_resp_t, DATA_WIDTH from shared core.svh; no local redefinition.
REQ-027 Entry typedef wb_entry_t (address, writedata, byte_enable) in shared core package.
REQ-028 One sub-module, wb_fifo (storage, pointers, count, parallel address-compare outputs); FSM and bus muxing in mem_write_buffer.

Verification
REQ-029 4 writes 0x100,0x104,0x108,0x10C, mem waitrequest=1 -> all accepted with waitrequest=0, 5th write stalls, wb_empty=0.
REQ-030 Buffer holds write 0x200=0xDEADBEEF, read 0x300 -> read issued to memory immediately, write still pending, count=1.
REQ-031 Buffer holds 0x200=0xDEADBEEF, read 0x200 -> DRAIN, write retires first, then read returns 0xDEADBEEF 1 cycle after accept.
REQ-032 Buffer holds 1 entry, read 0x80000000 -> drain to empty before read issued.
REQ-033 Full buffer, mem waitrequest=0 sustained with continuous upstream writes -> one pop per cycle, pointers wrap, memory order matches push order.
REQ-034 rst asserted with 3 entries pending -> next cycle count=0, wb_empty=1, no memory write issued.

Source files
------------

// File: rtl/mem_write_buffer_pkg.sv
// Shared Avalon bus types and write-buffer entry type for the memory port.
package mem_write_buffer_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;
    localparam int BE_WIDTH   = DATA_WIDTH / 8;

    typedef struct packed {
        logic                  read;
        logic                  write;
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] writedata;
        logic [BE_WIDTH-1:0]   byte_enable;
    } avalon_req_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] readdata;
        logic                  waitrequest;
    } avalon_resp_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] address;
        logic [DATA_WIDTH-1:0] writedata;
        logic [BE_WIDTH-1:0]   byte_enable;
    } wb_entry_t;

    typedef enum logic {
        NORMAL = 1'b0,
        DRAIN  = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular store of pending writes with a per-slot word-address comparator
// against the upstream read address.
module wb_fifo
    import mem_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic [ADDR_WIDTH-3:0] lookup_word,
    output wb_entry_t             head_entry,
    output logic [DEPTH-1:0]      match,
    output logic                  full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   cnt_t;

    wb_entry_t slots [DEPTH];
    ptr_t      head;
    ptr_t      tail;
    cnt_t      count;

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) tail <= tail + ptr_t'(1);
            if (pop)  head <= head + ptr_t'(1);
            if (push && !pop)      count <= count + cnt_t'(1);
            else if (pop && !push) count <= count - cnt_t'(1);
        end
    end

    // Payload is qualified purely by head/count, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) slots[tail] <= push_entry;
    end

    assign head_entry = slots[head];
    assign full       = (count == cnt_t'(DEPTH));
    assign empty      = (count == '0);

    for (genvar i = 0; i < DEPTH; i++) begin : g_cmp
        ptr_t age;
        assign age      = ptr_t'(i) - head;
        assign match[i] = ({1'b0, age} < count) &&
                          (slots[i].address[ADDR_WIDTH-1:2] == lookup_word);
    end

endmodule

// File: rtl/mem_write_buffer.sv
// Posted-write buffer between the cache memory port and the memory bus;
// reads bypass unless they hit a pending write or are non-cacheable.
module mem_write_buffer
    import mem_write_buffer_pkg::*;
#(
    parameter int WB_DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  avalon_req_t  cache_avn_req,
    output avalon_resp_t cache_avn_resp,
    output avalon_req_t  mem_avn_req,
    input  avalon_resp_t mem_avn_resp,
    output logic         wb_empty
);

    wb_state_t           state;
    wb_state_t           state_next;
    logic                wr_hold;
    logic                rd;
    logic                wr;
    logic                hazard;
    logic                push;
    logic                pop;
    logic                full;
    logic                empty;
    logic                issue_rd;
    logic                issue_wr;
    logic                up_wait;
    logic [WB_DEPTH-1:0] match;
    wb_entry_t           head;
    wb_entry_t           push_entry;

    // A read+write pair is a protocol error; the read wins.
    assign rd = cache_avn_req.read;
    assign wr = cache_avn_req.write & ~cache_avn_req.read;

    assign hazard = rd & ((|match) |
                          (cache_avn_req.address[ADDR_WIDTH-1] & ~empty));

    assign push_entry = '{address:     cache_avn_req.address,
                          writedata:   cache_avn_req.writedata,
                          byte_enable: cache_avn_req.byte_enable};

    wb_fifo #(
        .DEPTH(WB_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .lookup_word(cache_avn_req.address[ADDR_WIDTH-1:2]),
        .head_entry (head),
        .match      (match),
        .full       (full),
        .empty      (empty)
    );

    // wr_hold: a write stalled last cycle must stay on the bus unchanged.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= NORMAL;
            wr_hold <= 1'b0;
        end else begin
            state   <= state_next;
            wr_hold <= mem_avn_req.write & mem_avn_resp.waitrequest;
        end
    end

    always_comb begin
        state_next = state;
        up_wait    = 1'b0;
        issue_rd   = 1'b0;
        issue_wr   = 1'b0;
        push       = 1'b0;
        unique case (state)
            NORMAL: begin
                if (rd) begin
                    up_wait = 1'b1;
                    if (hazard) begin
                        state_next = DRAIN;
                        issue_wr   = wr_hold;
                    end else if (wr_hold) begin
                        issue_wr = 1'b1;
                    end else begin
                        issue_rd = 1'b1;
                    end
                end else begin
                    issue_wr = ~empty;
                    if (wr) begin
                        up_wait = full;
                        push    = ~full;
                    end
                end
            end
            DRAIN: begin
                up_wait = 1'b1;
                if (empty) begin
                    state_next = NORMAL;
                    issue_rd   = rd;
                end else begin
                    issue_wr = 1'b1;
                end
            end
        endcase
        if (rst) begin
            issue_rd = 1'b0;
            issue_wr = 1'b0;
            push     = 1'b0;
        end
        mem_avn_req = '0;
        if (issue_rd) begin
            mem_avn_req.read        = 1'b1;
            mem_avn_req.address     = cache_avn_req.address;
            mem_avn_req.byte_enable = cache_avn_req.byte_enable;
            up_wait                 = mem_avn_resp.waitrequest;
        end else if (issue_wr) begin
            mem_avn_req.write       = 1'b1;
            mem_avn_req.address     = head.address;
            mem_avn_req.writedata   = head.writedata;
            mem_avn_req.byte_enable = head.byte_enable;
        end
        pop = issue_wr & ~mem_avn_resp.waitrequest;
    end

    assign cache_avn_resp = '{readdata:    mem_avn_resp.readdata,
                              waitrequest: up_wait};

    assign wb_empty = empty;

endmodule

// File: tb/tb_mem_write_buffer.sv
// Randomized bench: a program-order memory model and a posted-write queue
// are checked against the buffer's bus traffic and read data.
module tb_mem_write_buffer;
    import mem_write_buffer_pkg::*;

    localparam int DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    avalon_req_t  cache_req;
    avalon_resp_t cache_resp;
    avalon_req_t  mem_req;
    avalon_resp_t mem_resp;
    logic         wb_empty;

    always #5 clk = ~clk;

    mem_write_buffer #(
        .WB_DEPTH(DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cache_avn_req (cache_req),
        .cache_avn_resp(cache_resp),
        .mem_avn_req   (mem_req),
        .mem_avn_resp  (mem_resp),
        .wb_empty      (wb_empty)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [79:0] got,
                       input logic [79:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    wb_entry_t   q[$];
    logic [31:0] memm [logic [29:0]];
    logic [31:0] arch [logic [29:0]];
    int          wait_mode;
    logic        accepted;
    int          last_n;
    logic        rd_next_valid;
    logic [31:0] rd_next_data;
    logic        exp_rd_valid;
    logic [31:0] exp_rd_data;
    avalon_req_t prev_req;
    logic        prev_stall;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] d,
                                          input logic [3:0]  be);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++)
            if (be[b]) r[8*b +: 8] = d[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mget(input logic [29:0] w);
        return memm.exists(w) ? memm[w] : 32'h0;
    endfunction

    function automatic logic [31:0] aget(input logic [29:0] w);
        return arch.exists(w) ? arch[w] : 32'h0;
    endfunction

    task automatic sample_cycle();
        int          sz;
        logic        hz;
        logic        mrd_ok;
        logic [29:0] w;
        accepted = 1'b0;
        if (rst) begin
            chk("rst_mem_wr", mem_req.write, 1'b0);
            chk("rst_mem_rd", mem_req.read, 1'b0);
            q.delete();
            arch          = memm;
            exp_rd_valid  = 1'b0;
            rd_next_valid = 1'b0;
            prev_stall    = 1'b0;
            return;
        end
        if (exp_rd_valid) chk("rd_data", cache_resp.readdata, exp_rd_data);
        exp_rd_valid = 1'b0;
        sz = q.size();
        chk("wb_empty", wb_empty, sz == 0);
        if (prev_stall) chk("mem_hold", mem_req, prev_req);
        chk("mem_rd_wr_excl", mem_req.read & mem_req.write, 1'b0);
        if (mem_req.write) begin
            chk("mem_wr_nonempty", sz != 0, 1'b1);
            if (sz != 0) begin
                chk("mem_wr_addr", mem_req.address, q[0].address);
                chk("mem_wr_data", mem_req.writedata, q[0].writedata);
                chk("mem_wr_be", mem_req.byte_enable, q[0].byte_enable);
                if (!mem_resp.waitrequest) begin
                    w = q[0].address[31:2];
                    memm[w] = merge(mget(w), q[0].writedata, q[0].byte_enable);
                    void'(q.pop_front());
                end
            end
        end
        if (mem_req.read) begin
            hz = 1'b0;
            foreach (q[i])
                if (q[i].address[31:2] == mem_req.address[31:2]) hz = 1'b1;
            if (mem_req.address[31] && sz != 0) hz = 1'b1;
            chk("mem_rd_hazard", hz, 1'b0);
            chk("mem_rd_req", cache_req.read, 1'b1);
            chk("mem_rd_addr", mem_req.address, cache_req.address);
            chk("mem_rd_be", mem_req.byte_enable, cache_req.byte_enable);
            if (!mem_resp.waitrequest) begin
                rd_next_valid = 1'b1;
                rd_next_data  = mget(mem_req.address[31:2]);
            end
        end
        mrd_ok = mem_req.read && !mem_resp.waitrequest;
        if (cache_req.read) begin
            chk("up_rd_wait", cache_resp.waitrequest, !mrd_ok);
            if (!cache_resp.waitrequest) begin
                accepted     = 1'b1;
                exp_rd_valid = 1'b1;
                exp_rd_data  = aget(cache_req.address[31:2]);
            end
        end else if (cache_req.write) begin
            chk("up_wr_wait", cache_resp.waitrequest, sz == DEPTH);
            if (!cache_resp.waitrequest) begin
                accepted = 1'b1;
                q.push_back('{address:     cache_req.address,
                              writedata:   cache_req.writedata,
                              byte_enable: cache_req.byte_enable});
                w = cache_req.address[31:2];
                arch[w] = merge(aget(w), cache_req.writedata,
                                cache_req.byte_enable);
            end
        end
        prev_req   = mem_req;
        prev_stall = (mem_req.read | mem_req.write) & mem_resp.waitrequest;
    endtask

    task automatic drive_wait();
        if (wait_mode == 0) mem_resp.waitrequest = ($urandom_range(0, 99) < 40);
        else                mem_resp.waitrequest = (wait_mode == 2);
    endtask

    task automatic set_wait(input int mode);
        wait_mode = mode;
        drive_wait();
    endtask

    task automatic step();
        #1;
        sample_cycle();
        @(posedge clk);
        #1;
        drive_wait();
        mem_resp.readdata = rd_next_valid ? rd_next_data : $urandom();
        rd_next_valid     = 1'b0;
    endtask

    task automatic xact(input logic r, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] be);
        int n;
        n = 0;
        cache_req = '{read: r, write: wr, address: a, writedata: d,
                      byte_enable: be};
        do begin
            step();
            n++;
        end while (!accepted && n < 300);
        chk("xact_done", accepted, 1'b1);
        last_n    = n;
        cache_req = '0;
    endtask

    task automatic settle();
        cache_req = '0;
        set_wait(1);
        for (int i = 0; i < 20 && !wb_empty; i++) step();
        step();
        step();
    endtask

    task automatic do_reset();
        cache_req = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          op;
        int          total;
        logic [31:0] a;
        rst           = 1'b1;
        cache_req     = '0;
        mem_resp      = '0;
        wait_mode     = 2;
        rd_next_valid = 1'b0;
        exp_rd_valid  = 1'b0;
        prev_stall    = 1'b0;

        do_reset();
        #1;
        chk("rst_wb_empty", wb_empty, 1'b1);
        chk("rst_up_wait", cache_resp.waitrequest, 1'b0);
        chk("rst_mem_idle", mem_req.read | mem_req.write, 1'b0);

        // Fill with memory stalled, then the fifth write must stall.
        set_wait(2);
        for (int i = 0; i < 4; i++) begin
            xact(1'b0, 1'b1, 32'h100 + 32'(4 * i), $urandom(), 4'hF);
            chk("fill_cycles", last_n, 1);
        end
        cache_req = '{read: 1'b0, write: 1'b1, address: 32'h110,
                      writedata: 32'h5555AAAA, byte_enable: 4'hF};
        step();
        chk("full_stall", accepted, 1'b0);
        chk("full_not_empty", wb_empty, 1'b0);

        // Streaming through a full buffer: one stall, then one per cycle.
        set_wait(1);
        total = 0;
        for (int i = 0; i < 8; i++) begin
            xact(1'b0, 1'b1, 32'h110 + 32'(4 * i), $urandom(), 4'hF);
            total += last_n;
        end
        chk("stream_cycles", total, 9);
        settle();

        // Non-hazard read goes straight out while the write stays queued.
        set_wait(1);
        xact(1'b0, 1'b1, 32'h200, 32'h11111111, 4'hF);
        cache_req = '{read: 1'b1, write: 1'b0, address: 32'h300,
                      writedata: 32'h0, byte_enable: 4'hF};
        step();
        chk("bypass_rd_now", accepted, 1'b1);
        chk("bypass_wr_pending", wb_empty, 1'b0);
        settle();

        // Hazard read: the write drains first, then the read sees it.
        set_wait(2);
        xact(1'b0, 1'b1, 32'h200, 32'hDEADBEEF, 4'hF);
        set_wait(1);
        xact(1'b1, 1'b0, 32'h200, 32'h0, 4'hF);
        #1;
        chk("drain_rd_data", cache_resp.readdata, 32'hDEADBEEF);
        chk("drain_empty", wb_empty, 1'b1);
        settle();

        // Non-cacheable read waits for an empty buffer.
        set_wait(2);
        xact(1'b0, 1'b1, 32'h40, 32'hCAFEF00D, 4'hF);
        set_wait(1);
        xact(1'b1, 1'b0, 32'h8000_0000, 32'h0, 4'hF);
        chk("nc_drained", wb_empty, 1'b1);
        settle();

        // Reset with three writes pending discards them.
        set_wait(2);
        for (int i = 0; i < 3; i++)
            xact(1'b0, 1'b1, 32'h120 + 32'(4 * i), $urandom(), 4'hF);
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_empty", wb_empty, 1'b1);
        chk("rst_mid_no_wr", mem_req.write, 1'b0);

        set_wait(0);
        for (int k = 0; k < 400; k++) begin
            op = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0)
                a = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 2);
            else
                a = 32'h100 + (32'($urandom_range(0, 7)) << 2);
            if (op < 2) begin
                do_reset();
            end else if (op < 12) begin
                cache_req = '0;
                step();
            end else if (op < 60) begin
                xact(1'b0, 1'b1, a, $urandom(), 4'($urandom_range(1, 15)));
            end else if (op < 92) begin
                xact(1'b1, 1'b0, a, 32'h0, 4'hF);
            end else begin
                xact(1'b1, 1'b1, a, $urandom(), 4'hF);
            end
        end
        settle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
